// File: rtl/io_dec_pkg.sv
// Shared types, default widths and address-compare helper for the IO strobe decoder.
package io_dec_pkg;

    localparam int unsigned DEF_NCH = 8;
    localparam int unsigned DEF_AW  = 8;
    localparam int unsigned DEF_WW  = 4;
    localparam int unsigned MAX_AW  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        DONE   = 2'd2,
        MISS   = 2'd3
    } state_t;

    // Masked equality: bits with mask=1 are compared, others are don't-care.
    function automatic logic addr_match(
        input logic [MAX_AW-1:0] addr,
        input logic [MAX_AW-1:0] base,
        input logic [MAX_AW-1:0] mask
    );
        return (addr & mask) == (base & mask);
    endfunction

    // Index width that stays legal for a single-channel build.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_addr_match.sv
// NCH-way masked address compare with lowest-index priority resolution.
module io_addr_match
    import io_dec_pkg::*;
#(
    parameter int unsigned       NCH  = DEF_NCH,
    parameter int unsigned       AW   = DEF_AW,
    parameter int unsigned       IW   = idx_width(NCH),
    parameter logic [NCH*AW-1:0] BASE = '0,
    parameter logic [NCH*AW-1:0] MASK = '1
) (
    input  logic [AW-1:0] addr,
    output logic          hit_c,
    output logic [IW-1:0] idx_c
);

    logic [NCH-1:0] match_c;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            match_c[i] = addr_match(MAX_AW'(addr),
                                    MAX_AW'(BASE[i*AW +: AW]),
                                    MAX_AW'(MASK[i*AW +: AW]));
        end
    end

    // Scan high to low so the lowest matching index is written last and wins.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (match_c[i]) begin
                hit_c = 1'b1;
                idx_c = IW'(i);
            end
        end
    end

endmodule

// File: rtl/io_strobe_decoder.sv
// Registered IO address decoder: per-channel chip selects, gated RD/WR strobes
// and per-channel wait states ending in READY.
module io_strobe_decoder
    import io_dec_pkg::*;
#(
    parameter int unsigned       NCH  = DEF_NCH,
    parameter int unsigned       AW   = DEF_AW,
    parameter int unsigned       WW   = DEF_WW,
    parameter logic [NCH*AW-1:0] BASE = '0,
    parameter logic [NCH*AW-1:0] MASK = '1,
    parameter logic [NCH*WW-1:0] WAIT = '0,
    localparam int unsigned      IW   = idx_width(NCH)
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           IOREQ,
    input  logic           RD,
    input  logic           WR,
    input  logic [AW-1:0]  ADDR,
    output logic [NCH-1:0] CS_N,
    output logic           RD_N,
    output logic           WR_N,
    output logic           READY,
    output logic           HIT,
    output logic [IW-1:0]  HIT_IDX
);

    state_t         state_q, state_d;
    logic [WW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] cs_n_q, cs_n_d;
    logic           rd_n_q, rd_n_d;
    logic           wr_n_q, wr_n_d;
    logic           ready_q, ready_d;
    logic           hit_q, hit_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           rel_c;

    logic           match_hit_c;
    logic [IW-1:0]  match_idx_c;

    io_addr_match #(
        .NCH  (NCH),
        .AW   (AW),
        .IW   (IW),
        .BASE (BASE),
        .MASK (MASK)
    ) u_match (
        .addr  (ADDR),
        .hit_c (match_hit_c),
        .idx_c (match_idx_c)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_n_q  <= '1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            ready_q <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            ready_q <= ready_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs hold by default; rel_c returns everything to idle values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        rd_n_d  = rd_n_q;
        wr_n_d  = wr_n_q;
        ready_d = ready_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        rel_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (IOREQ) begin
                    if (match_hit_c && (RD != WR)) begin
                        state_d = STROBE;
                        cnt_d   = WAIT[int'(match_idx_c)*WW +: WW];
                        cs_n_d  = ~(NCH'(1) << match_idx_c);
                        rd_n_d  = ~RD;
                        wr_n_d  = ~WR;
                        hit_d   = 1'b1;
                        idx_d   = match_idx_c;
                    end else begin
                        state_d = MISS;
                        ready_d = 1'b1;
                    end
                end
            end
            STROBE: begin
                if (!IOREQ) begin
                    rel_c = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - WW'(1);
                end
            end
            DONE, MISS: begin
                if (!IOREQ) begin
                    rel_c = 1'b1;
                end
            end
            default: begin
                rel_c = 1'b1;
            end
        endcase

        if (rel_c) begin
            state_d = IDLE;
            cnt_d   = '0;
            cs_n_d  = '1;
            rd_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            ready_d = 1'b0;
            hit_d   = 1'b0;
            idx_d   = '0;
        end
    end

    assign CS_N    = cs_n_q;
    assign RD_N    = rd_n_q;
    assign WR_N    = wr_n_q;
    assign READY   = ready_q;
    assign HIT     = hit_q;
    assign HIT_IDX = idx_q;

endmodule
